// File: rtl/vram_arbiter_if.sv
// Shared-SRAM arbiter bus bundle.
// Groups the screen, CPU and aux request/ack handshakes and the SRAM pins.
//   slave  : arbiter side (takes requests and vd_in, drives acks, data and SRAM strobes)
//   master : requester/SRAM side (the mirror image)
interface vram_arbiter_if;
  logic        scr_req;
  logic [18:0] scr_addr;
  logic        scr_ack;
  logic [7:0]  scr_data;
  logic        scr_overrun;

  logic        cpu_req;
  logic        cpu_wr;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;

  logic        aux_req;
  logic [18:0] aux_addr;
  logic [7:0]  aux_wdata;
  logic        aux_ack;

  logic [18:0] va;
  logic [7:0]  vd_in;
  logic [7:0]  vd_out;
  logic        vd_oe;
  logic        n_vrd;
  logic        n_vwr;

  modport slave (
    input  scr_req, scr_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
           aux_req, aux_addr, aux_wdata, vd_in,
    output scr_ack, scr_data, scr_overrun, cpu_rdata, cpu_ack, cpu_wait,
           aux_ack, va, vd_out, vd_oe, n_vrd, n_vwr
  );

  modport master (
    output scr_req, scr_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
           aux_req, aux_addr, aux_wdata, vd_in,
    input  scr_ack, scr_data, scr_overrun, cpu_rdata, cpu_ack, cpu_wait,
           aux_ack, va, vd_out, vd_oe, n_vrd, n_vwr
  );
endinterface

// File: rtl/vram_arbiter.sv
// Arbiter/sequencer for the shared 512K video/system SRAM.
// Screen fetch has fixed top priority; aux overrides CPU once its starve
// counter saturates at AUX_STARVE; otherwise CPU before aux.
// Ports:
//   clk28 - 28 MHz system clock
//   rst_n - async active-low reset
//   bus   - vram_arbiter_if.slave: request/ack handshakes and SRAM pins
//
// state | meaning
// IDLE  | bus quiet, arbitration happens on this edge
// RD1   | read strobe low, first cycle
// RD2   | read strobe low, data captured on the edge leaving
// WR1   | address/data setup, data driven
// WR2   | write strobe low
// WR3   | data hold, strobe high
module vram_arbiter #(
  parameter int unsigned AUX_STARVE = 15
) (
  input  logic          clk28,
  input  logic          rst_n,
  vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR1, S_WR2, S_WR3} state_t;
  typedef enum logic [1:0] {OWN_SCR, OWN_CPU, OWN_AUX} own_t;

  localparam logic [7:0] STARVE_MAX = 8'(AUX_STARVE);

  state_t      r_state;
  own_t        r_own;
  logic [18:0] r_va;
  logic [7:0]  r_vd_out;
  logic        r_vd_oe;
  logic        r_n_vrd;
  logic        r_n_vwr;
  logic        r_scr_pend;
  logic [18:0] r_scr_addr;
  logic        r_scr_overrun;
  logic        r_scr_ack;
  logic [7:0]  r_scr_data;
  logic        r_cpu_ack;
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_done;
  logic        r_cpu_wait;
  logic        r_aux_ack;
  logic [7:0]  r_aux_cnt;

  logic w_idle;
  logic w_scr_want;
  logic w_cpu_armed;
  logic w_aux_force;
  logic w_gnt_scr;
  logic w_gnt_aux;
  logic w_gnt_cpu;
  logic w_cpu_fin;

  assign w_idle      = (r_state == S_IDLE);
  assign w_scr_want  = r_scr_pend | bus.scr_req;
  assign w_cpu_armed = bus.cpu_req & ~r_cpu_done;
  assign w_aux_force = bus.aux_req & (r_aux_cnt == STARVE_MAX);
  assign w_gnt_scr   = w_idle & w_scr_want;
  assign w_gnt_aux   = w_idle & ~w_scr_want & (w_aux_force | (bus.aux_req & ~w_cpu_armed));
  assign w_gnt_cpu   = w_idle & ~w_scr_want & ~w_aux_force & w_cpu_armed;
  // Done must be visible on the IDLE edge right after the CPU access,
  // otherwise a held cpu_req would be granted a second time.
  assign w_cpu_fin   = (r_own == OWN_CPU) & ((r_state == S_RD2) | (r_state == S_WR3));

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_own         <= OWN_SCR;
      r_va          <= '0;
      r_vd_out      <= '0;
      r_vd_oe       <= 1'b0;
      r_n_vrd       <= 1'b1;
      r_n_vwr       <= 1'b1;
      r_scr_pend    <= 1'b0;
      r_scr_addr    <= '0;
      r_scr_overrun <= 1'b0;
      r_scr_ack     <= 1'b0;
      r_scr_data    <= '0;
      r_cpu_ack     <= 1'b0;
      r_cpu_rdata   <= '0;
      r_cpu_done    <= 1'b0;
      r_cpu_wait    <= 1'b0;
      r_aux_ack     <= 1'b0;
      r_aux_cnt     <= '0;
    end else begin
      r_scr_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_aux_ack <= 1'b0;

      // A request arriving on the granting edge of an older pending one
      // becomes the next pending request; otherwise a second request while
      // pending is dropped and flagged.
      if (w_gnt_scr) begin
        r_scr_pend <= r_scr_pend & bus.scr_req;
        if (r_scr_pend & bus.scr_req) r_scr_addr <= bus.scr_addr;
      end else if (bus.scr_req) begin
        if (r_scr_pend) begin
          r_scr_overrun <= 1'b1;
        end else begin
          r_scr_pend <= 1'b1;
          r_scr_addr <= bus.scr_addr;
        end
      end

      if (w_gnt_aux || !bus.aux_req)   r_aux_cnt <= '0;
      else if (r_aux_cnt != STARVE_MAX) r_aux_cnt <= r_aux_cnt + 8'd1;

      if (!bus.cpu_req)   r_cpu_done <= 1'b0;
      else if (w_cpu_fin) r_cpu_done <= 1'b1;
      r_cpu_wait <= bus.cpu_req & ~r_cpu_done;

      case (r_state)
        S_IDLE: begin
          if (w_gnt_scr) begin
            r_va    <= r_scr_pend ? r_scr_addr : bus.scr_addr;
            r_own   <= OWN_SCR;
            r_n_vrd <= 1'b0;
            r_state <= S_RD1;
          end else if (w_gnt_aux) begin
            r_va     <= bus.aux_addr;
            r_vd_out <= bus.aux_wdata;
            r_vd_oe  <= 1'b1;
            r_own    <= OWN_AUX;
            r_state  <= S_WR1;
          end else if (w_gnt_cpu) begin
            r_va  <= bus.cpu_addr;
            r_own <= OWN_CPU;
            if (bus.cpu_wr) begin
              r_vd_out <= bus.cpu_wdata;
              r_vd_oe  <= 1'b1;
              r_state  <= S_WR1;
            end else begin
              r_n_vrd <= 1'b0;
              r_state <= S_RD1;
            end
          end
        end
        S_RD1: r_state <= S_RD2;
        S_RD2: begin
          r_n_vrd <= 1'b1;
          r_state <= S_IDLE;
          if (r_own == OWN_SCR) begin
            r_scr_data <= bus.vd_in;
            r_scr_ack  <= 1'b1;
          end else begin
            r_cpu_rdata <= bus.vd_in;
            r_cpu_ack   <= 1'b1;
          end
        end
        S_WR1: begin
          r_n_vwr <= 1'b0;
          r_state <= S_WR2;
        end
        S_WR2: begin
          r_n_vwr <= 1'b1;
          r_state <= S_WR3;
        end
        S_WR3: begin
          r_vd_oe <= 1'b0;
          r_state <= S_IDLE;
          if (r_own == OWN_AUX) r_aux_ack <= 1'b1;
          else                  r_cpu_ack <= 1'b1;
        end
        default: begin
          r_n_vrd <= 1'b1;
          r_n_vwr <= 1'b1;
          r_vd_oe <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.va          = r_va;
  assign bus.vd_out      = r_vd_out;
  assign bus.vd_oe       = r_vd_oe;
  assign bus.n_vrd       = r_n_vrd;
  assign bus.n_vwr       = r_n_vwr;
  assign bus.scr_ack     = r_scr_ack;
  assign bus.scr_data    = r_scr_data;
  assign bus.scr_overrun = r_scr_overrun;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.cpu_wait    = r_cpu_wait;
  assign bus.aux_ack     = r_aux_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed timing scenarios followed by
// randomized traffic from three requesters, checked against a shadow memory
// that holds the value every completed write should have left behind.
module tb_vram_arbiter;

  logic clk28;
  logic rst_n;
  int   n_total;
  int   n_bad;
  bit   stop_cpu;

  vram_arbiter_if bus ();

  vram_arbiter #(.AUX_STARVE(15)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Asynchronous SRAM model: unwritten locations hold a fixed address hash.
  bit [7:0] mem    [0:524287];
  bit       mem_wr [0:524287];
  logic [7:0] shadow [int];

  function automatic logic [7:0] init_val(input logic [18:0] a);
    if (a == 19'h7C000) return 8'hA5;
    return a[7:0] ^ {a[18:15], a[11:8]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] shadow_rd(input logic [18:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  assign bus.vd_in = mem_wr[bus.va] ? mem[bus.va] : init_val(bus.va);

  always @(posedge clk28) begin
    if (!bus.n_vwr) begin
      mem[bus.va]    <= bus.vd_out;
      mem_wr[bus.va] <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk28);
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // Directed: screen read from IDLE.
  task automatic t_screen_read();
    tick();
    bus.scr_req = 1'b1; bus.scr_addr = 19'h7C000;
    tick(); bus.scr_req = 1'b0;
    check_eq("scr_rd1_nvrd", {31'd0, bus.n_vrd}, 32'd0);
    check_eq("scr_rd1_va", {13'd0, bus.va}, 32'h7C000);
    check_eq("scr_rd1_ack", {31'd0, bus.scr_ack}, 32'd0);
    tick();
    check_eq("scr_rd2_nvrd", {31'd0, bus.n_vrd}, 32'd0);
    tick();
    check_eq("scr_end_nvrd", {31'd0, bus.n_vrd}, 32'd1);
    check_eq("scr_ack_lat2", {31'd0, bus.scr_ack}, 32'd1);
    check_eq("scr_data", {24'd0, bus.scr_data}, 32'hA5);
    tick();
    check_eq("scr_ack_pulse", {31'd0, bus.scr_ack}, 32'd0);
    check_eq("scr_data_hold", {24'd0, bus.scr_data}, 32'hA5);
  endtask

  // Directed: screen request lands one edge after a CPU write grant.
  task automatic t_collision();
    tick();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 19'h10000; bus.cpu_wdata = 8'h3C;
    tick();
    check_eq("col_wr1_oe", {31'd0, bus.vd_oe}, 32'd1);
    check_eq("col_wr1_nvwr", {31'd0, bus.n_vwr}, 32'd1);
    check_eq("col_wr1_va", {13'd0, bus.va}, 32'h10000);
    bus.scr_req = 1'b1; bus.scr_addr = 19'h7C001;
    tick(); bus.scr_req = 1'b0;
    check_eq("col_wr2_nvwr", {31'd0, bus.n_vwr}, 32'd0);
    check_eq("col_wr2_oe", {31'd0, bus.vd_oe}, 32'd1);
    tick();
    check_eq("col_wr3_nvwr", {31'd0, bus.n_vwr}, 32'd1);
    check_eq("col_wr3_oe", {31'd0, bus.vd_oe}, 32'd1);
    tick();
    check_eq("col_cpu_ack", {31'd0, bus.cpu_ack}, 32'd1);
    check_eq("col_turn_oe", {31'd0, bus.vd_oe}, 32'd0);
    check_eq("col_turn_nvrd", {31'd0, bus.n_vrd}, 32'd1);
    check_eq("col_mem", {24'd0, mem[19'h10000]}, 32'h3C);
    shadow[int'(19'h10000)] = 8'h3C;
    bus.cpu_req = 1'b0;
    tick();
    check_eq("col_rd_va", {13'd0, bus.va}, 32'h7C001);
    check_eq("col_rd_nvrd", {31'd0, bus.n_vrd}, 32'd0);
    tick();
    check_eq("col_scr_early", {31'd0, bus.scr_ack}, 32'd0);
    tick();
    check_eq("col_scr_lat5", {31'd0, bus.scr_ack}, 32'd1);
    check_eq("col_scr_data", {24'd0, bus.scr_data}, {24'd0, shadow_rd(19'h7C001)});
  endtask

  // Directed: CPU read held high long after its ack.
  task automatic t_cpu_handshake();
    int bursts, acks, ack_i, wait_bad;
    logic prev_nvrd;
    logic [7:0] rd;
    bursts = 0; acks = 0; ack_i = 0; wait_bad = 0; prev_nvrd = 1'b1; rd = '0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 19'h20001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) check_eq("hs_wait_high", {31'd0, bus.cpu_wait}, 32'd1);
      if (prev_nvrd && !bus.n_vrd) bursts++;
      prev_nvrd = bus.n_vrd;
      if (bus.cpu_ack) begin
        acks++;
        ack_i = i;
        rd = bus.cpu_rdata;
      end
      if (ack_i > 0 && i > ack_i && bus.cpu_wait) wait_bad++;
    end
    check_eq("hs_bursts", bursts, 1);
    check_eq("hs_acks", acks, 1);
    check_eq("hs_ack_lat2", ack_i, 3);
    check_eq("hs_rdata", {24'd0, rd}, {24'd0, shadow_rd(19'h20001)});
    check_eq("hs_wait_low", wait_bad, 0);
    bus.cpu_req = 1'b0;
    drain(3);
  endtask

  // Aux held against a CPU that re-requests as soon as the done flag clears.
  // With screen interleaving, only the starve override can let aux in.
  task automatic t_starve(input bit with_scr, input logic [7:0] wd);
    int n, g;
    bit first_aux;
    stop_cpu = 1'b0;
    fork
      begin
        int guard;
        bus.cpu_wr = 1'b0; bus.cpu_addr = 19'h20005;
        tick(); bus.cpu_req = 1'b1;
        while (!stop_cpu) begin
          guard = 0;
          while (!bus.cpu_ack && !stop_cpu && guard < 60) begin tick(); guard++; end
          bus.cpu_req = 1'b0;
          if (with_scr) begin bus.scr_req = 1'b1; bus.scr_addr = 19'h7C010; end
          tick();
          bus.scr_req = 1'b0;
          if (!stop_cpu) bus.cpu_req = 1'b1;
        end
        bus.cpu_req = 1'b0;
      end
      begin
        drain(14);
        bus.aux_req = 1'b1; bus.aux_addr = 19'h00100; bus.aux_wdata = wd;
        n = 0;
        do begin
          tick(); n++;
        end while (!(bus.vd_oe && bus.n_vwr && bus.va == 19'h00100) && n < 40);
        if (with_scr) check_eq("stv_scr_bound", {31'd0, (n >= 16 && n <= 25)}, 32'd1);
        else          check_eq("stv_bound19", {31'd0, (n <= 19)}, 32'd1);
        first_aux = 1'b0; g = 0;
        do begin
          tick(); g++;
          if (bus.aux_ack) first_aux = 1'b1;
        end while (!bus.aux_ack && !bus.cpu_ack && g < 20);
        check_eq("stv_aux_first", {31'd0, first_aux}, 32'd1);
        bus.aux_req = 1'b0;
        check_eq("stv_mem", {24'd0, mem[19'h00100]}, {24'd0, wd});
        shadow[int'(19'h00100)] = wd;
        stop_cpu = 1'b1;
      end
    join
    drain(12);
  endtask

  // Directed: two screen pulses during a CPU write.
  task automatic t_overrun();
    int acks, stayed;
    logic [7:0] sd;
    acks = 0; stayed = 1; sd = '0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 19'h20010; bus.cpu_wdata = 8'h5C;
    tick();
    bus.scr_req = 1'b1; bus.scr_addr = 19'h7C003;
    tick();
    bus.scr_addr = 19'h7C004;
    tick();
    bus.scr_req = 1'b0;
    check_eq("ovr_set", {31'd0, bus.scr_overrun}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
      if (bus.scr_ack) begin acks++; sd = bus.scr_data; end
      if (!bus.scr_overrun) stayed = 0;
    end
    check_eq("ovr_acks", acks, 1);
    check_eq("ovr_first_addr", {24'd0, sd}, {24'd0, shadow_rd(19'h7C003)});
    check_eq("ovr_sticky", stayed, 1);
    check_eq("ovr_cpu_mem", {24'd0, mem[19'h20010]}, 32'h5C);
    shadow[int'(19'h20010)] = 8'h5C;
  endtask

  // Directed: reset asserted in the middle of an aux write strobe.
  task automatic t_reset_mid_write();
    int acks;
    acks = 0;
    tick();
    bus.aux_req = 1'b1; bus.aux_addr = 19'h00200; bus.aux_wdata = 8'h99;
    tick();
    check_eq("rst_wr1_oe", {31'd0, bus.vd_oe}, 32'd1);
    tick();
    check_eq("rst_wr2_nvwr", {31'd0, bus.n_vwr}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_nvwr", {31'd0, bus.n_vwr}, 32'd1);
    check_eq("rst_oe", {31'd0, bus.vd_oe}, 32'd0);
    check_eq("rst_va", {13'd0, bus.va}, 32'd0);
    check_eq("rst_ovr_clr", {31'd0, bus.scr_overrun}, 32'd0);
    bus.aux_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.aux_ack || bus.cpu_ack) acks++;
    end
    check_eq("rst_no_ack", acks, 0);
    check_eq("rst_no_write", {31'd0, mem_wr[19'h00200]}, 32'd0);
  endtask

  task automatic cpu_agent(input int n);
    for (int t = 0; t < n; t++) begin
      logic [18:0] a;
      logic [7:0] d;
      bit w;
      int g;
      repeat ($urandom_range(1, 3)) tick();
      a = 19'h20000 + 19'($urandom_range(0, 15));
      d = 8'($urandom);
      w = ($urandom_range(0, 1) == 1);
      bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wr = w; bus.cpu_req = 1'b1;
      g = 0;
      do begin tick(); g++; end while (!bus.cpu_ack && g < 80);
      check_eq("rnd_cpu_ack", {31'd0, bus.cpu_ack}, 32'd1);
      if (w) begin
        check_eq("rnd_cpu_wr", {24'd0, mem[a]}, {24'd0, d});
        shadow[int'(a)] = d;
      end else begin
        check_eq("rnd_cpu_rd", {24'd0, bus.cpu_rdata}, {24'd0, shadow_rd(a)});
      end
      bus.cpu_req = 1'b0;
    end
  endtask

  task automatic aux_agent(input int n);
    for (int t = 0; t < n; t++) begin
      logic [18:0] a;
      logic [7:0] d;
      int g;
      repeat ($urandom_range(1, 6)) tick();
      a = 19'h20000 + 19'($urandom_range(0, 15));
      d = 8'($urandom);
      bus.aux_addr = a; bus.aux_wdata = d; bus.aux_req = 1'b1;
      g = 0;
      do begin tick(); g++; end while (!bus.aux_ack && g < 80);
      check_eq("rnd_aux_ack", {31'd0, bus.aux_ack}, 32'd1);
      check_eq("rnd_aux_wr", {24'd0, mem[a]}, {24'd0, d});
      shadow[int'(a)] = d;
      bus.aux_req = 1'b0;
    end
  endtask

  task automatic scr_agent(input int n);
    for (int t = 0; t < n; t++) begin
      logic [18:0] a;
      int g;
      repeat ($urandom_range(2, 8)) tick();
      a = 19'h20000 + 19'($urandom_range(0, 15));
      bus.scr_addr = a; bus.scr_req = 1'b1;
      g = 0;
      do begin
        tick(); g++;
        if (g == 1) bus.scr_req = 1'b0;
      end while (!bus.scr_ack && g < 12);
      check_eq("rnd_scr_ack", {31'd0, bus.scr_ack}, 32'd1);
      // Latency counted from the sampling edge; worst case is a write that just began.
      check_eq("rnd_scr_lat", {31'd0, (g - 1 >= 2 && g - 1 <= 5)}, 32'd1);
      check_eq("rnd_scr_data", {24'd0, bus.scr_data}, {24'd0, shadow_rd(a)});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_bad = 0; stop_cpu = 1'b0;
    rst_n = 1'b0;
    bus.scr_req = 1'b0; bus.scr_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aux_req = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;
    drain(3);
    check_eq("rst0_nvrd", {31'd0, bus.n_vrd}, 32'd1);
    check_eq("rst0_nvwr", {31'd0, bus.n_vwr}, 32'd1);
    check_eq("rst0_oe", {31'd0, bus.vd_oe}, 32'd0);
    check_eq("rst0_va", {13'd0, bus.va}, 32'd0);
    check_eq("rst0_acks", {29'd0, bus.scr_ack, bus.cpu_ack, bus.aux_ack}, 32'd0);
    check_eq("rst0_wait", {31'd0, bus.cpu_wait}, 32'd0);
    check_eq("rst0_data", {16'd0, bus.scr_data, bus.cpu_rdata}, 32'd0);
    check_eq("rst0_ovr", {31'd0, bus.scr_overrun}, 32'd0);
    rst_n = 1'b1;
    drain(2);

    t_screen_read();
    drain(2);
    t_collision();
    drain(3);
    t_cpu_handshake();
    t_starve(1'b0, 8'h77);
    t_starve(1'b1, 8'h78);
    t_overrun();
    drain(3);
    t_reset_mid_write();
    drain(2);

    fork
      cpu_agent(40);
      aux_agent(25);
      scr_agent(30);
    join
    drain(10);
    check_eq("rnd_no_overrun", {31'd0, bus.scr_overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
